pipelined_barrel_rotator: RTL

PIPELINED_BARREL_ROTATOR -- requirements
Module: pipelined_barrel_rotator

---
 rtl/pipelined_barrel_rotator.sv | 80 ++++++++
 1 files changed

// File: rtl/pipelined_barrel_rotator.sv
// Pipelined barrel rotator/shifter: one barrel level per registered stage, with
// a global stall when the final result is valid but not yet taken downstream.
module pipelined_barrel_rotator #(
  parameter int WIDTH  = 32,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [LEVELS-1:0] amount,
  input  logic [2:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  data_out
);

  typedef enum logic [2:0] {
    OP_ROL = 3'b000,
    OP_ROR = 3'b001,
    OP_SLL = 3'b010,
    OP_SRL = 3'b011,
    OP_SRA = 3'b100
  } op_t;

  logic              advance;
  logic [LEVELS-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [LEVELS];
  logic [LEVELS-1:0] amt_q  [LEVELS];
  logic [2:0]        op_q   [LEVELS];

  // Each stage shifts by at most WIDTH/2, so rotate complements never reach WIDTH.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                            input logic [2:0] o,
                                            input logic en,
                                            input int unsigned sh);
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      case (o)
        OP_ROL:  r = (d << sh) | (d >> (WIDTH - sh));
        OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
        OP_SLL:  r = d << sh;
        OP_SRL:  r = d >> sh;
        OP_SRA:  r = $signed(d) >>> sh;
        default: r = d;
      endcase
    end
    return r;
  endfunction

  assign advance   = !valid_q[LEVELS-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[LEVELS-1];
  assign data_out  = data_q[LEVELS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < LEVELS; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        op_q[k]   <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      data_q[0]  <= step(data_in, op, amount[0], 1);
      amt_q[0]   <= amount;
      op_q[0]    <= op;
      for (int unsigned k = 1; k < LEVELS; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= step(data_q[k-1], op_q[k-1], amt_q[k-1][k], 32'd1 << k);
        amt_q[k]   <= amt_q[k-1];
        op_q[k]    <= op_q[k-1];
      end
    end
  end

endmodule
